// File: rtl/npu_isa_pkg.sv
// NPU 32-bit instruction format: opcodes, field widths and word packers.
// Shared by the instruction encoder and the instruction decoder.
package npu_isa_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_FE    = 2'b11
  } op_t;

  localparam int MAX_CHUNK   = 255;
  localparam int LINE_BYTES  = 16;
  localparam int LINE_SHIFT  = $clog2(LINE_BYTES);
  localparam int LDST_RF_W   = 9;
  localparam int LDST_LINE_W = 13;
  localparam int MOVE_ADDR_W = 10;
  localparam int FE_ADDR_W   = 24;
  localparam int EU_W        = 5;
  localparam int N_W         = 8;

  // {op[31:30], rf[29:21], sdram_line[20:8], n[7:0]}
  function automatic logic [31:0] pack_ldst(op_t op, logic [LDST_RF_W-1:0] rf,
                                            logic [LDST_LINE_W-1:0] line, logic [N_W-1:0] n);
    return {op, rf, line, n};
  endfunction

  // {2'b10, src[29:20], dst[19:10], sfrz[9], dfrz[8], n[7:0]}
  function automatic logic [31:0] pack_move(logic [MOVE_ADDR_W-1:0] src, logic [MOVE_ADDR_W-1:0] dst,
                                            logic sfrz, logic dfrz, logic [N_W-1:0] n);
    return {OP_MOVE, src, dst, sfrz, dfrz, n};
  endfunction

  // {2'b11, fun[29], eu[28:24], addr[23:0]}
  function automatic logic [31:0] pack_fe(logic fun, logic [EU_W-1:0] eu, logic [FE_ADDR_W-1:0] addr);
    return {OP_FE, fun, eu, addr};
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Command request and instruction stream bundle for inst_encoder.
// slave = the encoder itself, master = the command issuer / instruction sink.
interface inst_encoder_if #(
  parameter int RF_ADDR_W = 10,
  parameter int LINES_W   = 16
);
  import npu_isa_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  op_t                  req_op;
  logic                 req_fun;
  logic [RF_ADDR_W-1:0] req_src_addr;
  logic [RF_ADDR_W-1:0] req_dst_addr;
  logic [31:0]          req_ext_addr;
  logic [LINES_W-1:0]   req_lines;
  logic                 req_src_frz;
  logic                 req_dst_frz;
  logic [4:0]           req_eu;
  logic                 inst_valid;
  logic                 inst_ready;
  logic [31:0]          inst;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport slave (
    input  req_valid, req_op, req_fun, req_src_addr, req_dst_addr, req_ext_addr,
           req_lines, req_src_frz, req_dst_frz, req_eu, inst_ready,
    output req_ready, inst_valid, inst, busy, done, err
  );

  modport master (
    output req_valid, req_op, req_fun, req_src_addr, req_dst_addr, req_ext_addr,
           req_lines, req_src_frz, req_dst_frz, req_eu, inst_ready,
    input  req_ready, inst_valid, inst, busy, done, err
  );

endinterface

// File: rtl/inst_encoder.sv
// Packs LOAD/STORE/MOVE/FETCH/EXEC commands into NPU instruction words,
// splitting long transfers into chunks of at most MAX_CHUNK lines.
module inst_encoder
  import npu_isa_pkg::*;
#(
  parameter int RF_ADDR_W = 10,
  parameter int LINES_W   = 16
) (
  input logic           clk,
  input logic           rst_n,
  inst_encoder_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]             state;
  op_t                    op_q;
  logic [RF_ADDR_W-1:0]   src_q, dst_q;
  logic [LDST_LINE_W-1:0] line_q;
  logic [LINES_W-1:0]     rem_q;
  logic                   sfrz_q, dfrz_q;
  logic                   inst_valid_q, done_q, err_q;
  logic [31:0]            inst_q;

  op_t                    cur_op;
  logic [RF_ADDR_W-1:0]   cur_src, cur_dst, src_after, dst_after;
  logic [LDST_LINE_W-1:0] cur_line, line_after;
  logic [LINES_W-1:0]     cur_rem, rem_after;
  logic                   cur_sfrz, cur_dfrz;
  logic [N_W-1:0]         chunk_n;
  logic [31:0]            word;

  logic [LINES_W:0]       src_end, dst_end, line_end;
  logic                   is_ldst, is_move, is_fe, cmd_bad;

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.busy       = (state == ST_ISSUE);
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

  // Range checks are widened by one bit so an overflowing sum is caught, never wrapped.
  always_comb begin
    is_fe    = (bus.req_op == OP_FE);
    is_move  = (bus.req_op == OP_MOVE);
    is_ldst  = !is_fe && !is_move;
    src_end  = (LINES_W+1)'(bus.req_src_addr) + (LINES_W+1)'(bus.req_lines);
    dst_end  = (LINES_W+1)'(bus.req_dst_addr) + (LINES_W+1)'(bus.req_lines);
    line_end = (LINES_W+1)'(bus.req_ext_addr[16:LINE_SHIFT]) + (LINES_W+1)'(bus.req_lines);
    cmd_bad  = (bus.req_ext_addr[LINE_SHIFT-1:0] != '0)
            || (!is_fe && bus.req_lines == '0)
            || (is_fe && bus.req_ext_addr[31:28] != '0)
            || (is_ldst && (bus.req_ext_addr[31:17] != '0
                            || src_end > (LINES_W+1)'(512)
                            || line_end > (LINES_W+1)'(8192)))
            || (is_move && (src_end > (LINES_W+1)'(1 << RF_ADDR_W)
                            || dst_end > (LINES_W+1)'(1 << RF_ADDR_W)));
  end

  // The first chunk comes straight from the request, later chunks from the saved registers.
  always_comb begin
    cur_op   = op_q;
    cur_src  = src_q;
    cur_dst  = dst_q;
    cur_line = line_q;
    cur_rem  = rem_q;
    cur_sfrz = sfrz_q;
    cur_dfrz = dfrz_q;
    if (state == ST_IDLE) begin
      cur_op   = bus.req_op;
      cur_src  = bus.req_src_addr;
      cur_dst  = bus.req_dst_addr;
      cur_line = bus.req_ext_addr[16:LINE_SHIFT];
      cur_rem  = is_fe ? '0 : bus.req_lines;
      cur_sfrz = bus.req_src_frz;
      cur_dfrz = bus.req_dst_frz;
    end
    chunk_n    = (cur_rem > LINES_W'(MAX_CHUNK)) ? N_W'(MAX_CHUNK) : cur_rem[N_W-1:0];
    rem_after  = cur_rem - LINES_W'(chunk_n);
    src_after  = cur_src + RF_ADDR_W'(chunk_n);
    dst_after  = cur_dst + RF_ADDR_W'(chunk_n);
    line_after = cur_line + LDST_LINE_W'(chunk_n);
    case (cur_op)
      OP_MOVE: word = pack_move(MOVE_ADDR_W'(cur_src), MOVE_ADDR_W'(cur_dst), cur_sfrz, cur_dfrz, chunk_n);
      OP_FE:   word = pack_fe(bus.req_fun, bus.req_eu, bus.req_ext_addr[27:LINE_SHIFT]);
      default: word = pack_ldst(cur_op, LDST_RF_W'(cur_src), cur_line, chunk_n);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      op_q         <= OP_LOAD;
      src_q        <= '0;
      dst_q        <= '0;
      line_q       <= '0;
      rem_q        <= '0;
      sfrz_q       <= 1'b0;
      dfrz_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.req_valid) begin
          if (cmd_bad) begin
            err_q <= 1'b1;
          end else begin
            state        <= ST_ISSUE;
            op_q         <= cur_op;
            sfrz_q       <= cur_sfrz;
            dfrz_q       <= cur_dfrz;
            src_q        <= src_after;
            dst_q        <= dst_after;
            line_q       <= line_after;
            rem_q        <= rem_after;
            inst_q       <= word;
            inst_valid_q <= 1'b1;
          end
        end
      end else if (inst_valid_q && bus.inst_ready) begin
        if (rem_q == '0) begin
          state        <= ST_IDLE;
          inst_valid_q <= 1'b0;
          done_q       <= 1'b1;
        end else begin
          src_q  <= src_after;
          dst_q  <= dst_after;
          line_q <= line_after;
          rem_q  <= rem_after;
          inst_q <= word;
        end
      end
    end
  end

endmodule
